// File: rtl/burst_pkg.sv
// rtl/burst_pkg.sv - shared burst interface types, defaults and helpers
package burst_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        DATA = 2'd2
    } burst_state_t;

    localparam int BURST_CYCLES = 8;
    localparam int BURST_WIDTH  = 16;

    // Ceiling log2, never below 1 so a 2-deep buffer still gets a 1-bit index.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/burst_buffer_ram.sv
// rtl/burst_buffer_ram.sv - burst word storage, sync write, async read
module burst_buffer_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset; the caller gates out-of-range addresses.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Combinational read so the FSM can register the word on the same edge it advances.
    always_comb begin
        rd_data = mem[rd_addr];
    end

endmodule

// File: rtl/data_burst_tx.sv
// rtl/data_burst_tx.sv - burst transmitter: header cycle then CYCLES buffered words
module data_burst_tx
    import burst_pkg::*;
#(
    parameter int CYCLES = BURST_CYCLES,
    parameter int WIDTH  = BURST_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [clog2(CYCLES)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     wr_err,
    output logic                     out_start,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     done
);

    localparam int IW = clog2(CYCLES);
    localparam logic [IW-1:0] LAST  = IW'(CYCLES - 1);
    localparam logic [IW:0]   LIMIT = (IW + 1)'(CYCLES);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_HEAD = HEAD;
    localparam logic [1:0] ST_DATA = DATA;

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             wr_ok;

    // Writes only land while idle and in range, so an active burst never tears.
    assign wr_ok = wr_en && (state == ST_IDLE) && ({1'b0, wr_addr} < LIMIT);

    // Look one word ahead: the output register loads the word the next cycle will show.
    always_comb begin
        rd_addr = '0;
        if (state == ST_DATA && idx != LAST) rd_addr = idx + IW'(1);
    end

    burst_buffer_ram #(
        .DEPTH (CYCLES),
        .WIDTH (WIDTH),
        .AW    (IW)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Burst FSM with registered outputs; reset clears everything at once, truncating any burst.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            wr_err    <= 1'b0;
            out_start <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            wr_err    <= wr_en && !wr_ok;
            out_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_HEAD;
                        busy      <= 1'b1;
                        out_start <= 1'b1;
                    end
                end
                ST_HEAD: begin
                    state     <= ST_DATA;
                    idx       <= '0;
                    out_valid <= 1'b1;
                    out_data  <= rd_data;
                    done      <= 1'b0;
                end
                ST_DATA: begin
                    if (idx == LAST) begin
                        state     <= ST_IDLE;
                        idx       <= '0;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        done      <= 1'b0;
                    end else begin
                        idx      <= rd_addr;
                        out_data <= rd_data;
                        done     <= (rd_addr == LAST);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_burst_tx.sv
// tb/tb_data_burst_tx.sv - randomized self-checking bench with burst schedule model
module tb_data_burst_tx;

    localparam int CYCLES = 8;
    localparam int WIDTH  = 16;

    logic             clock;
    logic             reset_n;
    logic             wr_en;
    logic [2:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic             busy;
    logic             wr_err;
    logic             out_start;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             done;

    data_burst_tx #(.CYCLES(CYCLES), .WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .wr_err    (wr_err),
        .out_start (out_start),
        .out_valid (out_valid),
        .out_data  (out_data),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: buffer contents plus the edge number at which the current burst began.
    logic [WIDTH-1:0] mem_m [CYCLES];
    int  cyc     = 0;
    int  n0      = -1000;
    bit  exp_err = 1'b0;

    // Bench-side burst receiver: header at one edge, word i at the i+1-th following edge.
    logic [WIDTH-1:0] rx [CYCLES];
    int  rx_cnt = -1;
    int  hdr_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_err"},   32'(wr_err),    32'd0);
        check({tag, "_start"}, 32'(out_start), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"},  32'(out_data),  32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
    endtask

    // One clock: advance the model from the inputs seen at the edge, then compare after the edge.
    task automatic step();
        int  k;
        bit  idle_pre;
        logic [WIDTH-1:0] exp_data;
        @(posedge clock);
        exp_err = 1'b0;
        if (reset_n) begin
            idle_pre = (cyc - n0) >= CYCLES + 2;
            if (wr_en) begin
                if (idle_pre && int'(wr_addr) < CYCLES) mem_m[wr_addr] = wr_data;
                else exp_err = 1'b1;
            end
            if (start && idle_pre) n0 = cyc;
        end else begin
            n0 = -1000;
        end
        k = cyc - n0;
        cyc++;
        #1;
        exp_data = (k >= 1 && k <= CYCLES) ? mem_m[k-1] : '0;
        check("busy",      32'(busy),      32'(k >= 0 && k <= CYCLES));
        check("wr_err",    32'(wr_err),    32'(exp_err));
        check("out_start", 32'(out_start), 32'(k == 0));
        check("out_valid", 32'(out_valid), 32'(k >= 1 && k <= CYCLES));
        check("out_data",  32'(out_data),  32'(exp_data));
        check("done",      32'(done),      32'(k == CYCLES));
        if (out_start) begin
            rx_cnt = 0;
            hdr_q.push_back(cyc);
        end else if (rx_cnt >= 0 && rx_cnt < CYCLES && out_valid) begin
            rx[rx_cnt] = out_data;
            rx_cnt++;
        end
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1;
        idle_inputs();
        #3 reset_n = 1'b0;
        #1 check_idle_outputs("reset");
        step(); step();
        reset_n = 1'b1;

        // Load 0x1000..0x1007 and send one burst.
        for (int i = 0; i < CYCLES; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 16'h1000 + 16'(i);
            step();
        end
        idle_inputs();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < CYCLES + 3; i++) step();
        for (int i = 0; i < CYCLES; i++) check("rx_word", 32'(rx[i]), 32'h1000 + 32'(i));

        // Write during DATA is rejected; both this burst and the next keep 0x1003.
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hDEAD; step();
        idle_inputs();
        for (int i = 0; i < CYCLES + 2; i++) step();
        check("rx_word3_during", 32'(rx[3]), 32'h1003);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < CYCLES + 2; i++) step();
        check("rx_word3_next", 32'(rx[3]), 32'h1003);

        // start held for 30 cycles: headers exactly 10 cycles apart.
        hdr_q.delete();
        start = 1'b1;
        for (int i = 0; i < 30; i++) step();
        start = 1'b0;
        for (int i = 0; i < CYCLES + 2; i++) step();
        check("held_bursts", 32'(hdr_q.size()), 32'd3);
        for (int i = 1; i < hdr_q.size(); i++)
            check("burst_spacing", 32'(hdr_q[i] - hdr_q[i-1]), 32'(CYCLES + 2));

        // Reset while word 4 is on the bus, then a full burst afterwards.
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("pre_reset_word", 32'(out_data), 32'h1004);
        #2 reset_n = 1'b0;
        #1 check_idle_outputs("midreset");
        rx_cnt = -1;
        step(); step();
        reset_n = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < CYCLES + 2; i++) step();
        for (int i = 0; i < CYCLES; i++) check("rx_after_reset", 32'(rx[i]), 32'h1000 + 32'(i));

        // Write and start together in IDLE: the burst carries the new word.
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hBEEF; start = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < CYCLES + 2; i++) step();
        check("rx_beef", 32'(rx[0]), 32'hBEEF);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            start   = ($urandom_range(0, 3) == 0);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 3'($urandom_range(0, CYCLES - 1));
            wr_data = 16'($urandom);
            step();
        end
        idle_inputs();
        for (int i = 0; i < CYCLES + 2; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_burst_tx.md
# data_burst_tx

Transmit side of the 8-word burst interface. The block holds a CYCLES-deep word buffer that host logic loads through a simple write port. On a start request it emits a one-cycle `out_start` header, then drives the buffered words on `out_data` in consecutive clock cycles, index 0 first. The cycle-level framing is exactly what the burst receiver (`data_buffer`) captures: the header is sampled at one rising edge, and word *i* is sampled at the *i*+1-th following edge.

## Interface
- `CYCLES`, 8, words per burst; legal range 2..256.
- `WIDTH`, 16, data word width in bits.
- `clock` input 1: single clock; all sampling on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `wr_en` input 1: buffer write strobe.
- `wr_addr` input clog2(CYCLES): buffer write index.
- `wr_data` input WIDTH: buffer write data.
- `start` input 1: request one burst (level sampled).
- `busy` output 1: high while a burst is in progress.
- `wr_err` output 1: one-cycle pulse when a write is rejected.
- `out_start` output 1: burst header, feeds receiver `data_start`.
- `out_valid` output 1: high while `out_data` carries a burst word.
- `out_data` output WIDTH: burst word; 0 when `out_valid` is low.
- `done` output 1: one-cycle pulse, coincident with the last word.

## Operation
- All outputs are registered.
- Reset values: `busy`, `wr_err`, `out_start`, `out_valid`, `done` = 0; `out_data` = 0; state = IDLE; index = 0.
- Buffer contents are not reset.
- **IDLE**
  - `start`=1 at an edge: go to HEAD; `busy` rises.
- **HEAD** (exactly one cycle)
  - `out_start`=1, `out_valid`=0.
  - Next state is DATA with index = 0.
- **DATA**
  - `out_valid`=1, `out_data`=buffer[index].
  - Index increments each cycle.
  - When index = CYCLES-1: `done`=1; next state IDLE; `busy` falls at the end of that cycle.
- **start handling**
  - `start` in HEAD or DATA is ignored and not queued.
  - `start` held high continuously produces back-to-back bursts. Each burst is separated by exactly one IDLE cycle, in which `start` is resampled.
- **Writes**
  - Accepted only in IDLE: buffer[`wr_addr`] <= `wr_data`.
  - `wr_en` in HEAD or DATA: the write is dropped and `wr_err` pulses the following cycle. The buffer is unchanged, so a burst never tears.
  - `wr_addr` >= CYCLES (non-power-of-2 CYCLES): the write is dropped and `wr_err` pulses.
  - `wr_en` and `start` in the same IDLE cycle: the write completes first, and the burst transmits the new value.
- **Reset mid-burst**: outputs are forced to their reset values immediately (asynchronously). The receiver sees a truncated burst, with no further `out_valid` or `done`.
- Index width is clog2(CYCLES). The index never wraps past CYCLES-1.

## Timing
- `start` sampled at edge E0.
- `out_start`=1 during the cycle E0→E1.
- Word *i* is valid during cycle E(i+1)→E(i+2) for i = 0..CYCLES-1.
- `done` is high during E(CYCLES)→E(CYCLES+1).
- Latency from start edge to first word edge: 2 clocks. Total burst occupancy: CYCLES+1 clocks.
- Minimum start-to-start spacing: CYCLES+2 clocks.
- `wr_err`: 1-cycle latency after the offending edge.

## Structure
- Shared package `burst_pkg`:
  - state enum `burst_state_t` {IDLE, HEAD, DATA}
  - default `BURST_CYCLES`=8 and `BURST_WIDTH`=16
  - `clog2` helper function
  - These are reused by the receiver.
- Sub-module `burst_buffer_ram`:
  - CYCLES×WIDTH storage
  - one synchronous write port, one combinational read port indexed by the FSM counter
  - The top level holds the FSM, counter, output registers and write gating.

## Test plan
- Reset, load words 0x1000..0x1007, pulse `start` → `out_start` 1 cycle later; then 0x1000..0x1007 on 8 consecutive cycles with `out_valid`=1; `done` with 0x1007; `busy` low afterwards.
- Bench-connected `data_buffer` receiver → its buffer[0..7] equals the loaded words exactly.
- `wr_en` (addr 3, data 0xDEAD) during DATA → `wr_err` pulse; burst word 3 and the subsequent burst still carry the old value.
- `start` held high for 30 cycles (CYCLES=8) → bursts begin every 10 cycles; no `start` captured mid-burst.
- `reset_n` low at word 4 → all outputs 0 within the same cycle; `start` after release → a full burst from word 0.
- `wr_en` + `start` in the same IDLE cycle (addr 0, data 0xBEEF) → first burst word is 0xBEEF.
